// File: rtl/klp_pkg.sv
// Shared definitions for the front end: NOP encoding, RV32 major opcodes and the
// fetch-stage state encoding.
package klp_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;   // addi x0, x0, 0

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/instr_fetch_fifo.sv
// Small synchronous FIFO holding {instr, pc} pairs between imem and decode.
// Flush wins over push/pop; DEPTH must be a power of two so pointers wrap freely.
module instr_fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [AW:0]   count_q;
    logic          push_ok, pop_ok;

    assign pop_ok  = pop && (count_q != '0);
    assign push_ok = push && ((count_q != (AW+1)'(DEPTH)) || pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues word reads to imem, buffers returned words and
// handles control redirects. Define IF_MISALIGN_CHK_EN to fault on misaligned targets.
module instr_fetch
    import klp_pkg::*;
#(
    parameter int           n         = 32,
    parameter logic [n-1:0] RESET_PC  = '0,
    parameter int           BUF_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic         imem_req,
    output logic [n-1:0] imem_addr,
    input  logic         imem_gnt,
    input  logic         imem_rvalid,
    input  logic [n-1:0] imem_rdata,
    input  logic         stall,
    input  logic         PCSel,
    input  logic [n-1:0] br_target,
    output logic [n-1:0] instr,
    output logic [n-1:0] pc,
    output logic         instr_valid
`ifdef IF_MISALIGN_CHK_EN
    ,
    output logic         fetch_fault
`endif
);
    localparam int CW = $clog2(BUF_DEPTH + 1);

    fetch_state_e state_q;
    logic [n-1:0] fetch_pc_q, resp_pc_q, last_pc_q, tgt_al;
    logic [CW-1:0] outst_q, drop_q, drop_d, fifo_cnt;
    logic [CW:0]   occ;
    logic [2*n-1:0] head;
    logic redirect, issue, push, pop, fifo_empty, misalign, halt;

`ifdef IF_MISALIGN_CHK_EN
    logic fault_q;
    assign misalign    = (br_target[1:0] != 2'b00);
    assign halt        = fault_q;
    assign fetch_fault = fault_q;
`else
    assign misalign = 1'b0;
    assign halt     = 1'b0;
`endif

    always_comb begin
        redirect  = PCSel && instr_valid && !stall;
        tgt_al    = br_target & ~n'(3);
        occ       = {1'b0, fifo_cnt} + {1'b0, outst_q};
        imem_req  = (state_q == RUN) && !halt && !redirect && (occ < (CW+1)'(BUF_DEPTH));
        imem_addr = fetch_pc_q;
        issue     = imem_req && imem_gnt;
        // responses already in flight at a redirect belong to the old path
        push      = imem_rvalid && (drop_q == '0) && !redirect;
        pop       = instr_valid && !stall && !redirect;
        if (redirect)                         drop_d = outst_q - CW'(imem_rvalid);
        else if (imem_rvalid && drop_q != '0) drop_d = drop_q - CW'(1);
        else                                  drop_d = drop_q;
    end

    instr_fetch_fifo #(.DEPTH(BUF_DEPTH), .W(2*n)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata ({imem_rdata, resp_pc_q}),
        .rdata (head),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign instr_valid = !fifo_empty;
    assign instr       = fifo_empty ? n'(NOP_INSTR) : head[2*n-1:n];
    assign pc          = fifo_empty ? last_pc_q : head[n-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            last_pc_q  <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
`ifdef IF_MISALIGN_CHK_EN
            fault_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                BOOT:    state_q <= RUN;
                RUN:     if (redirect && outst_q != '0) state_q <= DRAIN;
                DRAIN:   if (drop_d == '0) state_q <= RUN;
                default: state_q <= BOOT;
            endcase
            if (instr_valid) last_pc_q <= pc;
            outst_q <= outst_q + CW'(issue) - CW'(imem_rvalid);
            drop_q  <= drop_d;
            if (redirect) begin
                if (!misalign) begin
                    fetch_pc_q <= tgt_al;
                    resp_pc_q  <= tgt_al;
                end
`ifdef IF_MISALIGN_CHK_EN
                else fault_q <= 1'b1;
`endif
            end else begin
                if (issue) fetch_pc_q <= fetch_pc_q + n'(4);
                if (push)  resp_pc_q  <= resp_pc_q + n'(4);
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: two instances (depth 2 / reset PC 0, depth 4 /
// reset PC FFFF_FFF8), a 1-cycle imem model each, and a scoreboard of expected pcs.
module tb_instr_fetch;
    import klp_pkg::*;

    localparam logic [31:0] RPC_B = 32'hFFFF_FFF8;

    logic clk, rst_n;
    logic req_a, gnt_a, rv_a, stall_a, pcsel_a, ival_a;
    logic req_b, gnt_b, rv_b, stall_b, pcsel_b, ival_b;
    logic [31:0] addr_a, rdata_a, tgt_a, instr_a, pc_a;
    logic [31:0] addr_b, rdata_b, tgt_b, instr_b, pc_b;
`ifdef IF_MISALIGN_CHK_EN
    logic fault_a, fault_b;
`endif
    logic hold_a, hold_b;
    logic [31:0] infl_a[$], infl_b[$], log_b[$], sb_a[$], sb_b[$];
    int n_checks = 0;
    int n_errs = 0;

    instr_fetch #(.n(32), .RESET_PC(32'h0), .BUF_DEPTH(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .imem_req(req_a), .imem_addr(addr_a), .imem_gnt(gnt_a),
        .imem_rvalid(rv_a), .imem_rdata(rdata_a), .stall(stall_a), .PCSel(pcsel_a),
        .br_target(tgt_a), .instr(instr_a), .pc(pc_a), .instr_valid(ival_a)
`ifdef IF_MISALIGN_CHK_EN
        , .fetch_fault(fault_a)
`endif
    );

    instr_fetch #(.n(32), .RESET_PC(RPC_B), .BUF_DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .imem_req(req_b), .imem_addr(addr_b), .imem_gnt(gnt_b),
        .imem_rvalid(rv_b), .imem_rdata(rdata_b), .stall(stall_b), .PCSel(pcsel_b),
        .br_target(tgt_b), .instr(instr_b), .pc(pc_b), .instr_valid(ival_b)
`ifdef IF_MISALIGN_CHK_EN
        , .fetch_fault(fault_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    // imem: record issues at negedge, answer in order one cycle later unless held
    always @(negedge clk) begin
        if (!rst_n) begin
            infl_a.delete(); infl_b.delete(); log_b.delete();
        end else begin
            if (rv_a) void'(infl_a.pop_front());
            if (rv_b) void'(infl_b.pop_front());
            if (req_a && gnt_a) infl_a.push_back(addr_a);
            if (req_b && gnt_b) begin infl_b.push_back(addr_b); log_b.push_back(addr_b); end
        end
    end

    always @(posedge clk) begin
        #2;
        rv_a    = rst_n && !hold_a && (infl_a.size() > 0);
        rdata_a = rv_a ? memf(infl_a[0]) : 32'h0;
        rv_b    = rst_n && !hold_b && (infl_b.size() > 0);
        rdata_b = rv_b ? memf(infl_b[0]) : 32'h0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        logic [31:0] e;
        if (ival_a && !stall_a) begin
            if (sb_a.size() == 0) chk("a_unexpected_instr", pc_a, 32'hFFFF_FFFF);
            else begin
                e = sb_a.pop_front();
                chk("a_pc", pc_a, e);
                chk("a_instr", instr_a, memf(e));
            end
        end
        if (ival_b && !stall_b) begin
            if (sb_b.size() == 0) chk("b_unexpected_instr", pc_b, 32'hFFFF_FFFF);
            else begin
                e = sb_b.pop_front();
                chk("b_pc", pc_b, e);
                chk("b_instr", instr_b, memf(e));
            end
        end
    endtask

    // leaves time at posedge+1, the input drive point
    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic obs();
        #3;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall_a = 1'b1; stall_b = 1'b1; pcsel_a = 1'b0; pcsel_b = 1'b0;
        tgt_a = '0; tgt_b = '0; gnt_a = 1'b1; gnt_b = 1'b1; hold_a = 1'b0; hold_b = 1'b0;
        sb_a.delete(); sb_b.delete();
        tick(); tick(); obs();
        chk("rst_a_req", 32'(req_a), 0);
        chk("rst_a_valid", 32'(ival_a), 0);
        chk("rst_a_instr", instr_a, NOP_INSTR);
        chk("rst_a_pc", pc_a, 32'h0);
        chk("rst_b_req", 32'(req_b), 0);
        chk("rst_b_pc", pc_b, RPC_B);
        rst_n = 1'b1;
    endtask

    task automatic drain_a(input int lim);
        int k = 0;
        stall_a = 1'b0;
        while (sb_a.size() > 0 && k < lim) begin tick(); k++; end
        stall_a = 1'b1;
        chk("a_drain_left", 32'(sb_a.size()), 0);
    endtask

    task automatic drain_b(input int lim);
        int k = 0;
        stall_b = 1'b0;
        while (sb_b.size() > 0 && k < lim) begin tick(); k++; end
        stall_b = 1'b1;
        chk("b_drain_left", 32'(sb_b.size()), 0);
    endtask

    task automatic wait_valid_a();
        int k = 0;
        while (!ival_a && k < 20) begin tick(); k++; end
        chk("a_valid_timeout", 32'(ival_a), 1);
    endtask

    // B: one word buffered (pc RPC_B) and two further reads held in flight
    task automatic setup_b2();
        int k = 0;
        gnt_b = 1'b0;
        while (!req_b && k < 20) begin tick(); k++; end
        chk("b_req_timeout", 32'(req_b), 1);
        gnt_b = 1'b1; tick(); gnt_b = 1'b0;
        tick(); tick();
        chk("b_first_valid", 32'(ival_b), 1);
        chk("b_first_pc", pc_b, RPC_B);
        hold_b = 1'b1; gnt_b = 1'b1;
        tick(); tick();
        gnt_b = 1'b0;
        chk("b_outstanding", 32'(dut_b.outst_q), 2);
    endtask

    initial begin
        logic [31:0] exp5 [3];
        exp5[0] = 32'hFFFF_FFF8; exp5[1] = 32'hFFFF_FFFC; exp5[2] = 32'h0000_0000;
        rv_a = 1'b0; rv_b = 1'b0; rdata_a = '0; rdata_b = '0;

        // 1: in-order stream from reset
        do_reset();
        begin
            int k = 0;
            while (!req_a && k < 20) begin tick(); k++; end
        end
        obs();
        chk("t1_req", 32'(req_a), 1);
        chk("t1_first_addr", addr_a, 32'h0);
        tick();
        sb_a.push_back(32'h0); sb_a.push_back(32'h4); sb_a.push_back(32'h8);
        drain_a(40);

        // 2: stall holds output, fills buffer, ignores PCSel; no loss on release
        do_reset();
        wait_valid_a();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin pcsel_a = 1'b1; tgt_a = 32'h300; end
            obs();
            chk("t2_stall_valid", 32'(ival_a), 1);
            chk("t2_stall_pc", pc_a, 32'h0);
            chk("t2_stall_instr", instr_a, memf(32'h0));
            if (i >= 2) chk("t2_req_full", 32'(req_a), 0);
            tick();
            pcsel_a = 1'b0;
        end
        sb_a.push_back(32'h0); sb_a.push_back(32'h4);
        sb_a.push_back(32'h8); sb_a.push_back(32'hC);
        drain_a(40);

        // 3: redirect with two reads outstanding
        do_reset();
        setup_b2();
        sb_b.push_back(RPC_B);
        pcsel_b = 1'b1; tgt_b = 32'h100; stall_b = 1'b0;
        tick();
        pcsel_b = 1'b0; stall_b = 1'b1; hold_b = 1'b0;
        chk("t3_state", 32'(dut_b.state_q), 32'(DRAIN));
        chk("t3_drop_cnt", 32'(dut_b.drop_q), 2);
        chk("t3_flushed", 32'(ival_b), 0);
        sb_b.push_back(32'h100); sb_b.push_back(32'h104);
        gnt_b = 1'b1;
        drain_b(40);

        // 4: redirect coinciding with a response
        do_reset();
        setup_b2();
        sb_b.push_back(RPC_B);
        hold_b = 1'b0;
        pcsel_b = 1'b1; tgt_b = 32'h200; stall_b = 1'b0;
        tick();
        pcsel_b = 1'b0; stall_b = 1'b1;
        chk("t4_drop_cnt", 32'(dut_b.drop_q), 1);
        chk("t4_outstanding", 32'(dut_b.outst_q), 1);
        sb_b.push_back(32'h200); sb_b.push_back(32'h204);
        gnt_b = 1'b1;
        drain_b(40);

        // 5: PC wraps through the top of the address space
        do_reset();
        sb_b.push_back(exp5[0]); sb_b.push_back(exp5[1]); sb_b.push_back(exp5[2]);
        drain_b(40);
        for (int i = 0; i < 3; i++)
            chk("t5_issue_addr", (log_b.size() > i) ? log_b[i] : 32'hFFFF_FFFF, exp5[i]);

        // 6: misaligned target
        do_reset();
        wait_valid_a();
        tick(); tick();
        sb_a.push_back(32'h0);
        pcsel_a = 1'b1; tgt_a = 32'h102; stall_a = 1'b0;
        obs();
        chk("t6_req_redirect", 32'(req_a), 0);
        tick();
        pcsel_a = 1'b0; stall_a = 1'b1;
        obs();
        chk("t6_empty_valid", 32'(ival_a), 0);
        chk("t6_empty_instr", instr_a, NOP_INSTR);
        chk("t6_empty_pc_hold", pc_a, 32'h0);
`ifdef IF_MISALIGN_CHK_EN
        chk("t6_fault", 32'(fault_a), 1);
        for (int i = 0; i < 4; i++) begin
            tick(); obs();
            chk("t6_no_issue", 32'(req_a), 0);
            chk("t6_fault_sticky", 32'(fault_a), 1);
        end
`else
        sb_a.push_back(32'h100); sb_a.push_back(32'h104);
        tick();
        drain_a(40);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
